// File: rtl/mux_scan.sv
// Multi-channel source multiplexer with manual select or timed auto-scan.
// Every channel shares one registered source index; outputs update one edge after their inputs.
module mux_scan #(
  parameter int WIDTH   = 1,
  parameter int NUM_CH  = 8,
  parameter int NUM_SRC = 3,
  parameter int DWELL   = 4,
  localparam int SW     = $clog2(NUM_SRC + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_CH*NUM_SRC*WIDTH-1:0] data_in,
  input  logic [SW-1:0]                   sel,
  input  logic                            mode,
  input  logic                            hold,
  output logic [NUM_CH*WIDTH-1:0]         data_out,
  output logic [SW-1:0]                   cur_src,
  output logic                            src_chg,
  output logic                            sel_err
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic {
    MANUAL,
    SCAN
  } state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [SW-1:0]           cur_src_q, cur_src_d;
  logic [NUM_CH*WIDTH-1:0] data_out_q, data_out_d;
  logic                    src_chg_q, src_chg_d;
  logic                    sel_err_q, sel_err_d;

  logic                    sel_ok;
  logic [SW-1:0]           dec_src;
  logic [SW-1:0]           next_src;

  // sel counts sources 1-based; 0 is shorthand for the last source.
  assign sel_ok   = (sel <= SW'(NUM_SRC));
  assign dec_src  = (sel == '0) ? SW'(NUM_SRC - 1) : sel - SW'(1);
  assign next_src = (cur_src_q == SW'(NUM_SRC - 1)) ? '0 : cur_src_q + SW'(1);

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can leave it unassigned and infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_src_d  = cur_src_q;
    data_out_d = data_out_q;
    src_chg_d  = 1'b0;
    sel_err_d  = 1'b0;

    if (!hold) begin
      if (mode) begin
        state_d = SCAN;
        if (state_q != SCAN) begin
          cnt_d = '0;
        end else if (cnt_q == CW'(DWELL - 1)) begin
          cnt_d     = '0;
          cur_src_d = next_src;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end else begin
        state_d = MANUAL;
        cnt_d   = '0;
        if (sel_ok) cur_src_d = dec_src;
        else        sel_err_d = 1'b1;
      end

      src_chg_d = (cur_src_d != cur_src_q);

      // Words are re-sampled every non-hold edge, even when the source index is unchanged.
      for (int c = 0; c < NUM_CH; c++) begin
        data_out_d[c*WIDTH +: WIDTH] =
          data_in[(c*NUM_SRC + int'(cur_src_d))*WIDTH +: WIDTH];
      end
    end
  end

  // NOTE: state is written with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= MANUAL;
      cnt_q      <= '0;
      cur_src_q  <= '0;
      data_out_q <= '0;
      src_chg_q  <= 1'b0;
      sel_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_src_q  <= cur_src_d;
      data_out_q <= data_out_d;
      src_chg_q  <= src_chg_d;
      sel_err_q  <= sel_err_d;
    end
  end

  assign data_out = data_out_q;
  assign cur_src  = cur_src_q;
  assign src_chg  = src_chg_q;
  assign sel_err  = sel_err_q;

endmodule

// File: doc/mux_scan.md
MUX_SCAN -- requirements
Module: mux_scan

Interface
REQ-001 Parameter WIDTH, default 1, bits per source word per channel (SHALL be >= 1).
REQ-002 Parameter NUM_CH, default 8, number of independent output channels (SHALL be >= 1).
REQ-003 Parameter NUM_SRC, default 3, sources per channel (SHALL be 2..15).
REQ-004 Parameter DWELL, default 4, cycles each source is held in scan mode (SHALL be >= 1).
REQ-005 Localparam SW = clog2(NUM_SRC+1) SHALL set the sel width (2 for defaults).
REQ-006 clk  input  1  single clock; all state SHALL update on the rising edge only.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 data_in  input  NUM_CH*NUM_SRC*WIDTH  source k of channel c at bits [(c*NUM_SRC+k)*WIDTH +: WIDTH], k 0-based.
REQ-009 sel  input  SW  manual source select.
REQ-010 mode  input  1  0 = manual, 1 = auto-scan.
REQ-011 hold  input  1  1 freezes all outputs and the scan state.
REQ-012 data_out  output  NUM_CH*WIDTH  registered selected word of channel c at [c*WIDTH +: WIDTH].
REQ-013 cur_src  output  SW  registered 0-based index of the source currently driving data_out.
REQ-014 src_chg  output  1  one-cycle pulse when cur_src changes value.
REQ-015 sel_err  output  1  registered flag, 1 while manual sel is out of range.

Function
REQ-016 Manual sel decode: sel = 0 SHALL select source NUM_SRC-1; sel = k, 1 <= k <= NUM_SRC, SHALL select source k-1.
REQ-017 Manual sel > NUM_SRC: the block SHALL keep the previous cur_src and data_out source, and SHALL set sel_err = 1 that cycle.
REQ-018 sel_err SHALL be 0 in scan mode, during hold, and for in-range sel.
REQ-019 Latency: data_out, cur_src and sel_err SHALL reflect the inputs sampled at edge N by the end of edge N (one-cycle registered latency).
REQ-020 All channels SHALL use the same cur_src; channels SHALL NOT interact otherwise.
REQ-021 Scan state machine states: MANUAL, SCAN; mode=1 -> SCAN, mode=0 -> MANUAL, evaluated every non-hold cycle.
REQ-022 SCAN: a dwell counter (0..DWELL-1) SHALL increment each non-hold cycle; on reaching DWELL-1 it SHALL clear and cur_src SHALL advance by 1.
REQ-023 SCAN wrap-around: cur_src = NUM_SRC-1 SHALL advance to 0.
REQ-024 MANUAL -> SCAN entry: scanning SHALL start from the current cur_src with dwell counter cleared; first advance after DWELL cycles in SCAN.
REQ-025 SCAN -> MANUAL: cur_src SHALL take the decoded sel on that same edge; dwell counter SHALL clear.
REQ-026 data_out SHALL always equal the data_in words of the source indicated by the new cur_src, sampled at the same edge.
REQ-027 hold = 1 SHALL override mode and sel: data_out, cur_src and dwell counter SHALL keep their values, src_chg = 0, sel_err = 0.
REQ-028 src_chg SHALL be 1 for exactly the cycle after any edge where cur_src is updated to a different value, 0 otherwise (including same-source reselect).
REQ-029 DWELL = 1 SHALL advance cur_src every non-hold SCAN cycle.

Reset
REQ-030 rst = 1 at an edge SHALL set data_out = 0, cur_src = 0, src_chg = 0, sel_err = 0, dwell counter = 0, state = MANUAL, overriding hold, mode and sel.
REQ-031 rst mid-scan SHALL abandon the dwell count; the first non-reset cycle SHALL behave as a fresh MANUAL/SCAN entry per REQ-021/REQ-024.
REQ-032 Outputs SHALL NOT change asynchronously with rst.

Verification (defaults WIDTH=1, NUM_CH=8, NUM_SRC=3, DWELL=4 unless stated)
REQ-033 rst, then mode=0, sel=0,1,2,3 with channel 0 sources {s0,s1,s2}={1,0,0},{0,1,0},{0,0,1} -> data_out[0] one cycle later = s2, s0, s1, s2; cur_src = 2,0,1,2.
REQ-034 mode=0, sel=1, then sel=3 (max 3 legal), then WIDTH=4 build with NUM_SRC=3 and sel=3 -> sel_err stays 0; with NUM_SRC=2 build sel=3 -> sel_err=1, cur_src unchanged, data_out unchanged.
REQ-035 mode=1 from cur_src=0 for 13 cycles -> cur_src sequence 0x4,1x4,2x4,0; src_chg pulses exactly after cycles 4, 8, 12.
REQ-036 mode=1, hold=1 for 3 cycles mid-dwell, changing data_in -> data_out, cur_src frozen, src_chg=0; after release the dwell resumes with remaining count.
REQ-037 mode=1 at cur_src=1 with dwell count 2, assert rst one cycle -> data_out=0, cur_src=0, src_chg=0; next advance occurs 4 cycles after rst deasserts.
REQ-038 mode=0, sel=2 repeated -> src_chg pulses once only; mode 1->0 with sel=2 while cur_src=1 -> cur_src=1 the next cycle... then SHALL read 1 (sel=2 -> source 1), src_chg=0.
